pc_sequencer: RTL and testbench

Program-counter stage of the single-cycle CPU. It holds the current PC and drives instruction memory and the `A` operand of the PC-increment `Adder`. Each cycle it selects the next PC from the sequential, branch, jump or register-indirect target, and commits it on the clock edge. It also implements a boot/run/halt state machine, stall hold, a retired-instruction counter and a sticky misaligned-target flag.

---
 rtl/pc_sequencer.sv | 105 ++++++++++
 tb/tb_pc_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Purpose : program-counter stage; holds PC, selects next PC, boot/run/halt sequencing.
// Latency : new PC visible one clock after the instruction is presented; PC4 is combinational.
// Backpressure: Stall holds PC, state, retired count and Misaligned for that cycle.
//
// Ports:
//   CLK, Reset              clock and asynchronous active-high reset
//   Stall, Halt             hold this cycle / decoded halt at current PC
//   PCSrc, Zero             next-PC select (seq/branch/jump/register), branch qualifier
//   Imm, JumpAddr, RegAddr  branch word offset, jump field, jr target
//   PC, PC4                 current PC and PC+4
//   Running                 high while in RUN
//   InstCount, Misaligned   retired-instruction count, sticky misaligned-jr flag
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Halt,
  input  logic [1:0]  PCSrc,
  input  logic        Zero,
  input  logic [31:0] Imm,
  input  logic [25:0] JumpAddr,
  input  logic [31:0] RegAddr,
  output logic [31:0] PC,
  output logic [31:0] PC4,
  output logic        Running,
  output logic [31:0] InstCount,
  output logic        Misaligned
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        mis_q, mis_d;
  logic [31:0] target;

  assign PC         = pc_q;
  assign PC4        = pc_q + 32'd4;
  assign InstCount  = cnt_q;
  assign Misaligned = mis_q;
  // Derived straight from the state flop, so it changes only on the
  // BOOT->RUN and RUN->HALTED edges (or asynchronously on reset).
  assign Running    = (state_q == ST_RUN);

  // Next-PC target; all sums wrap modulo 2^32, negative Imm included.
  always_comb begin
    target = PC4;
    case (PCSrc)
      2'b00:   target = PC4;
      2'b01:   target = Zero ? (PC4 + (Imm << 2)) : PC4;
      2'b10:   target = {PC4[31:28], JumpAddr, 2'b00};
      default: target = {RegAddr[31:2], 2'b00};
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    case (state_q)
      // One idle edge after reset: nothing advances, nothing is counted.
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (!Stall) begin
          cnt_d = cnt_q + 32'd1;
          if (Halt) begin
            // Halt instruction retires but the PC stays on it.
            state_d = ST_HALTED;
          end else begin
            pc_d = target;
            if (PCSrc == 2'b11 && RegAddr[1:0] != 2'b00) begin
              mis_d = 1'b1;
            end
          end
        end
      end
      default: begin
        // HALTED is absorbing; only Reset leaves it.
      end
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= 32'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// traffic compared against a behavioural PC/counter model.
module tb_pc_sequencer;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        Stall = 1'b0;
  logic        Halt = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic        Zero = 1'b0;
  logic [31:0] Imm = 32'd0;
  logic [25:0] JumpAddr = 26'd0;
  logic [31:0] RegAddr = 32'd0;
  logic [31:0] PC, PC4, InstCount;
  logic        Running, Misaligned;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_st;
  logic [31:0] m_pc, m_cnt;
  logic        m_mis;

  pc_sequencer #(.RESET_PC(RPC)) dut (
    .CLK(CLK), .Reset(Reset), .Stall(Stall), .Halt(Halt), .PCSrc(PCSrc),
    .Zero(Zero), .Imm(Imm), .JumpAddr(JumpAddr), .RegAddr(RegAddr),
    .PC(PC), .PC4(PC4), .Running(Running), .InstCount(InstCount),
    .Misaligned(Misaligned)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_st  = M_BOOT;
    m_pc  = RPC;
    m_cnt = 32'd0;
    m_mis = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] seq;
    if (Reset) begin
      model_reset();
      return;
    end
    seq = m_pc + 32'd4;
    if (m_st == M_BOOT) begin
      m_st = M_RUN;
    end else if (m_st == M_RUN && !Stall) begin
      m_cnt = m_cnt + 32'd1;
      if (Halt) begin
        m_st = M_HALT;
      end else begin
        case (PCSrc)
          2'd0: m_pc = seq;
          2'd1: m_pc = Zero ? seq + Imm * 32'd4 : seq;
          2'd2: m_pc = (seq & 32'hF000_0000) | ({6'd0, JumpAddr} * 32'd4);
          default: begin
            m_pc = RegAddr & 32'hFFFF_FFFC;
            if ((RegAddr & 32'h3) != 32'd0) m_mis = 1'b1;
          end
        endcase
      end
    end
  endtask

  task automatic drive(input logic s, input logic h, input logic [1:0] src, input logic z,
                       input logic [31:0] imm, input logic [25:0] ja, input logic [31:0] ra);
    Stall = s; Halt = h; PCSrc = src; Zero = z; Imm = imm; JumpAddr = ja; RegAddr = ra;
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    model_reset();
    #1;
    Reset = 1'b0;
  endtask

  task automatic goto_pc(input logic [31:0] a);
    drive(1'b0, 1'b0, 2'b11, 1'b0, 32'd0, 26'd0, a);
    tick();
  endtask

  task automatic test_reset();
    #1 Reset = 1'b1;
    model_reset();
    #2;
    checks++; if (PC !== RPC) begin errors++; $display("FAIL reset_pc got %h want %h", PC, RPC); end
    checks++; if (PC4 !== RPC + 32'd4) begin errors++; $display("FAIL reset_pc4 got %h want %h", PC4, RPC + 32'd4); end
    checks++; if (Running !== 1'b0) begin errors++; $display("FAIL reset_running got %b want 0", Running); end
    checks++; if (InstCount !== 32'd0) begin errors++; $display("FAIL reset_count got %h want 0", InstCount); end
    checks++; if (Misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis got %b want 0", Misaligned); end
    tick();
    tick();
    checks++; if (PC !== RPC || Running !== 1'b0) begin errors++; $display("FAIL reset_held pc=%h run=%b want %h/0", PC, Running, RPC); end
    Reset = 1'b0;
  endtask

  task automatic test_boot_sequence();
    logic [31:0] exp_pc;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 26'd0, 32'd0);
    tick();
    checks++; if (PC !== 32'd0 || Running !== 1'b1) begin errors++; $display("FAIL boot_edge pc=%h run=%b want 0/1", PC, Running); end
    checks++; if (InstCount !== 32'd0) begin errors++; $display("FAIL boot_count got %h want 0", InstCount); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp_pc = 32'(i * 4);
      checks++; if (PC !== exp_pc) begin errors++; $display("FAIL seq_pc got %h want %h", PC, exp_pc); end
    end
    checks++; if (InstCount !== 32'd3) begin errors++; $display("FAIL seq_count got %h want 3", InstCount); end
  endtask

  task automatic test_branch();
    goto_pc(32'h10);
    drive(1'b0, 1'b0, 2'b01, 1'b1, 32'hFFFF_FFFE, 26'd0, 32'd0);
    tick();
    checks++; if (PC !== 32'h0C) begin errors++; $display("FAIL branch_taken got %h want %h", PC, 32'h0C); end
    goto_pc(32'h10);
    drive(1'b0, 1'b0, 2'b01, 1'b0, 32'hFFFF_FFFE, 26'd0, 32'd0);
    tick();
    checks++; if (PC !== 32'h14) begin errors++; $display("FAIL branch_not_taken got %h want %h", PC, 32'h14); end
    checks++; if (InstCount !== m_cnt) begin errors++; $display("FAIL branch_count got %h want %h", InstCount, m_cnt); end
  endtask

  task automatic test_jump_jr();
    goto_pc(32'h4000_0000);
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 26'h000_0040, 32'd0);
    tick();
    checks++; if (PC !== 32'h4000_0100) begin errors++; $display("FAIL jump got %h want %h", PC, 32'h4000_0100); end
    checks++; if (Misaligned !== 1'b0) begin errors++; $display("FAIL jump_mis got %b want 0", Misaligned); end
    goto_pc(32'h0000_0203);
    checks++; if (PC !== 32'h200 || Misaligned !== 1'b1) begin errors++; $display("FAIL jr_mis pc=%h mis=%b want 200/1", PC, Misaligned); end
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 26'd0, 32'd0);
    tick();
    checks++; if (PC !== 32'h204 || Misaligned !== 1'b1) begin errors++; $display("FAIL mis_sticky pc=%h mis=%b want 204/1", PC, Misaligned); end
  endtask

  task automatic test_stall_halt();
    logic [31:0] cnt0;
    goto_pc(32'h20);
    cnt0 = m_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 2'($urandom_range(0, 3)), 1'b1, 32'd5, 26'h3FF, 32'h1234_5677);
      tick();
      checks++; if (PC !== 32'h20 || InstCount !== cnt0) begin errors++; $display("FAIL stall pc=%h cnt=%h want 20/%h", PC, InstCount, cnt0); end
    end
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'd0, 26'd0, 32'd0);
    tick();
    checks++; if (Running !== 1'b1 || InstCount !== cnt0) begin errors++; $display("FAIL stall_beats_halt run=%b cnt=%h want 1/%h", Running, InstCount, cnt0); end
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'd0, 26'd0, 32'd0);
    tick();
    checks++; if (PC !== 32'h20 || InstCount !== cnt0 + 32'd1 || Running !== 1'b0) begin
      errors++; $display("FAIL halt pc=%h cnt=%h run=%b want 20/%h/0", PC, InstCount, Running, cnt0 + 32'd1);
    end
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 26'h2AA_AAAA, 32'd0);
    tick();
    tick();
    checks++; if (PC !== 32'h20 || InstCount !== cnt0 + 32'd1 || Running !== 1'b0) begin
      errors++; $display("FAIL halted_frozen pc=%h cnt=%h run=%b want 20/%h/0", PC, InstCount, Running, cnt0 + 32'd1);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 26'd0, 32'd0);
    tick();
    goto_pc(32'h41);
    checks++; if (PC !== 32'h40 || Misaligned !== 1'b1) begin errors++; $display("FAIL pre_async pc=%h mis=%b want 40/1", PC, Misaligned); end
    Stall = 1'b1;
    #3;
    Reset = 1'b1;
    model_reset();
    #1;
    checks++; if (PC !== RPC || InstCount !== 32'd0 || Running !== 1'b0 || Misaligned !== 1'b0) begin
      errors++; $display("FAIL async_reset pc=%h cnt=%h run=%b mis=%b want %h/0/0/0", PC, InstCount, Running, Misaligned, RPC);
    end
    #1 Reset = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 26'd0, 32'd0);
    tick();
    checks++; if (PC !== RPC || Running !== 1'b1 || InstCount !== 32'd0) begin
      errors++; $display("FAIL reboot_edge pc=%h run=%b cnt=%h want %h/1/0", PC, Running, InstCount, RPC);
    end
    tick();
    checks++; if (PC !== RPC + 32'd4 || InstCount !== 32'd1) begin
      errors++; $display("FAIL reboot_advance pc=%h cnt=%h want %h/1", PC, InstCount, RPC + 32'd4);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 26'd0, 32'd0);
    tick();
    goto_pc(32'hFFFF_FFFC);
    checks++; if (PC4 !== 32'd0) begin errors++; $display("FAIL pc4_wrap got %h want 0", PC4); end
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 26'd0, 32'd0);
    tick();
    checks++; if (PC !== 32'd0) begin errors++; $display("FAIL pc_wrap got %h want 0", PC); end
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    checks++; if (InstCount !== 32'hFFFF_FFFF) begin errors++; $display("FAIL count_preload got %h want ffffffff", InstCount); end
    tick();
    checks++; if (InstCount !== 32'd0) begin errors++; $display("FAIL count_wrap got %h want 0", InstCount); end
  endtask

  task automatic test_random();
    logic [31:0] imm, ra;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      imm = $urandom_range(0, 64);
      imm = imm - 32'd32;
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra = ra & 32'hFFFF_FFFC;
      drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 39) == 0),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), imm,
            26'($urandom), ra);
      tick();
      checks++; if (PC !== m_pc) begin errors++; $display("FAIL rnd_pc cyc %0d got %h want %h", i, PC, m_pc); end
      checks++; if (PC4 !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_pc4 cyc %0d got %h want %h", i, PC4, m_pc + 32'd4); end
      checks++; if (Running !== (m_st == M_RUN)) begin errors++; $display("FAIL rnd_running cyc %0d got %b want %b", i, Running, m_st == M_RUN); end
      checks++; if (InstCount !== m_cnt) begin errors++; $display("FAIL rnd_count cyc %0d got %h want %h", i, InstCount, m_cnt); end
      checks++; if (Misaligned !== m_mis) begin errors++; $display("FAIL rnd_mis cyc %0d got %b want %b", i, Misaligned, m_mis); end
      if (m_st == M_HALT && $urandom_range(0, 5) == 0) do_reset();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_boot_sequence();
    test_branch();
    test_jump_jr();
    test_stall_halt();
    test_async_reset();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
